// File: rtl/fft_sched_if.sv
// Handshake and strobe bundle between fft_sched and the FFT datapath/sample source.
// master = scheduler side, slave = datapath/source side.
interface fft_sched_if;
  logic       val_i;
  logic       rdy_o;
  logic       wr_en_o;
  logic [5:0] wr_addr_o;
  logic       core_val_o;
  logic [2:0] grp_o;
  logic       stg_o;
  logic       wb_en_o;
  logic [2:0] wb_grp_o;
  logic       wb_stg_o;
  logic       val_o;
  logic [5:0] rd_addr_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    input  val_i,
    output rdy_o, wr_en_o, wr_addr_o, core_val_o, grp_o, stg_o,
    output wb_en_o, wb_grp_o, wb_stg_o, val_o, rd_addr_o, busy_o, done_o
  );

  modport slave (
    output val_i,
    input  rdy_o, wr_en_o, wr_addr_o, core_val_o, grp_o, stg_o,
    input  wb_en_o, wb_grp_o, wb_stg_o, val_o, rd_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/fft_sched.sv
// 64-point FFT control: bit-reversed load, two radix-8 passes through a shared core, natural-order unload.
// Latency: first val_o 17+2*CORE_LAT cycles after the last sample; input accepted only in LOAD.
module fft_sched #(
  parameter int LOG2_SIZE_FFT = 6,
  parameter int NUM_GRP       = 8,
  parameter int CORE_LAT      = 1
) (
  input  logic      clk,
  input  logic      rst,
  fft_sched_if.master bus
);
  localparam int W = LOG2_SIZE_FFT;
  localparam logic [W-1:0] CNT_LAST = W'((1 << LOG2_SIZE_FFT) - 1);
  localparam logic [W-1:0] GRP_LAST = W'(NUM_GRP - 1);
  localparam logic [W-1:0] DRN_LAST = (CORE_LAT > 0) ? W'(CORE_LAT - 1) : '0;

  typedef enum logic [2:0] {LOAD, STG0, DRN0, STG1, DRN1, UNLD} state_t;

  state_t       r_state, w_nxt_state;
  logic [W-1:0] r_cnt, w_nxt_cnt;
  logic         w_acc;
  logic         w_nxt_core;

  logic         r_rdy, r_core_val, r_stg, r_val_o, r_busy, r_done;
  logic [2:0]   r_grp;
  logic [5:0]   r_rd_addr;

  assign w_acc = bus.val_i & r_rdy;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      LOAD: if (w_acc) begin
        if (r_cnt == CNT_LAST) begin
          w_nxt_state = STG0;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      STG0: if (r_cnt == GRP_LAST) begin
        w_nxt_state = (CORE_LAT == 0) ? STG1 : DRN0;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
      DRN0: if (r_cnt == DRN_LAST) begin
        w_nxt_state = STG1;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
      STG1: if (r_cnt == GRP_LAST) begin
        w_nxt_state = (CORE_LAT == 0) ? UNLD : DRN1;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
      DRN1: if (r_cnt == DRN_LAST) begin
        w_nxt_state = UNLD;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
      UNLD: if (r_cnt == CNT_LAST) begin
        w_nxt_state = LOAD;
        w_nxt_cnt   = '0;
      end else begin
        w_nxt_cnt = r_cnt + 1'b1;
      end
      default: begin
        w_nxt_state = LOAD;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  assign w_nxt_core = (w_nxt_state == STG0) || (w_nxt_state == STG1);

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LOAD;
      r_cnt      <= '0;
      r_rdy      <= 1'b1;
      r_core_val <= 1'b0;
      r_grp      <= '0;
      r_stg      <= 1'b0;
      r_val_o    <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_rdy      <= (w_nxt_state == LOAD);
      r_core_val <= w_nxt_core;
      r_grp      <= w_nxt_core ? w_nxt_cnt[2:0] : 3'd0;
      r_stg      <= (w_nxt_state == STG1);
      r_val_o    <= (w_nxt_state == UNLD);
      r_rd_addr  <= (w_nxt_state == UNLD) ? 6'(w_nxt_cnt) : 6'd0;
      r_busy     <= (w_nxt_state != LOAD);
      r_done     <= (w_nxt_state == UNLD) && (w_nxt_cnt == CNT_LAST);
    end
  end

  always_comb begin
    bus.wr_addr_o = '0;
    for (int i = 0; i < W; i++) bus.wr_addr_o[i] = r_cnt[W-1-i];
  end

  assign bus.rdy_o      = r_rdy;
  assign bus.wr_en_o    = w_acc;
  assign bus.core_val_o = r_core_val;
  assign bus.grp_o      = r_grp;
  assign bus.stg_o      = r_stg;
  assign bus.val_o      = r_val_o;
  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.busy_o     = r_busy;
  assign bus.done_o     = r_done;

  // Writeback strobes track the issued group through the core pipeline.
  if (CORE_LAT == 0) begin : g_wb_pass
    assign bus.wb_en_o  = r_core_val;
    assign bus.wb_grp_o = r_grp;
    assign bus.wb_stg_o = r_stg;
  end else begin : g_wb_dly
    logic [CORE_LAT-1:0] r_wb_val;
    logic [CORE_LAT-1:0] r_wb_stg;
    logic [2:0]          r_wb_grp [CORE_LAT];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wb_val <= '0;
        r_wb_stg <= '0;
        for (int i = 0; i < CORE_LAT; i++) r_wb_grp[i] <= '0;
      end else begin
        r_wb_val[0] <= r_core_val;
        r_wb_stg[0] <= r_stg;
        r_wb_grp[0] <= r_grp;
        for (int i = 1; i < CORE_LAT; i++) begin
          r_wb_val[i] <= r_wb_val[i-1];
          r_wb_stg[i] <= r_wb_stg[i-1];
          r_wb_grp[i] <= r_wb_grp[i-1];
        end
      end
    end

    assign bus.wb_en_o  = r_wb_val[CORE_LAT-1];
    assign bus.wb_grp_o = r_wb_grp[CORE_LAT-1];
    assign bus.wb_stg_o = r_wb_stg[CORE_LAT-1];
  end
endmodule

// File: tb/tb_fft_sched.sv
// Directed bench for fft_sched: one DUT with CORE_LAT=1, one with CORE_LAT=0.
// Cycle T+n is observed at the negedge following the n-th rising edge after the last accepted sample.
module tb_fft_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fft_sched_if bus1 ();
  fft_sched_if bus0 ();

  fft_sched #(.LOG2_SIZE_FFT(6), .NUM_GRP(8), .CORE_LAT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  fft_sched #(.LOG2_SIZE_FFT(6), .NUM_GRP(8), .CORE_LAT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  // Packed view: {core_val, grp, stg, wb_en, wb_grp, wb_stg, val_o, rd_addr, done, busy, rdy, wr_en}
  function automatic logic [20:0] obs1();
    return {bus1.core_val_o, bus1.grp_o, bus1.stg_o, bus1.wb_en_o, bus1.wb_grp_o, bus1.wb_stg_o,
            bus1.val_o, bus1.rd_addr_o, bus1.done_o, bus1.busy_o, bus1.rdy_o, bus1.wr_en_o};
  endfunction

  function automatic logic [20:0] obs0();
    return {bus0.core_val_o, bus0.grp_o, bus0.stg_o, bus0.wb_en_o, bus0.wb_grp_o, bus0.wb_stg_o,
            bus0.val_o, bus0.rd_addr_o, bus0.done_o, bus0.busy_o, bus0.rdy_o, bus0.wr_en_o};
  endfunction

  // {core_val, grp, stg} expected in cycle T+n
  function automatic logic [4:0] cvgs(int n, int lat);
    int s1;
    s1 = 9 + lat;
    if (n >= 1 && n <= 8) return {1'b1, 3'(n - 1), 1'b0};
    if (n >= s1 && n <= s1 + 7) return {1'b1, 3'(n - s1), 1'b1};
    return 5'd0;
  endfunction

  function automatic logic [20:0] exp_vec(int n, int lat, logic vin);
    int         u;
    logic       vo;
    logic       busy;
    logic [5:0] ra;
    u    = 17 + 2 * lat;
    vo   = (n >= u) && (n <= u + 63);
    ra   = vo ? 6'(n - u) : 6'd0;
    busy = (n >= 1) && (n <= u + 63);
    return {cvgs(n, lat), cvgs(n - lat, lat), vo, ra, (n == u + 63), busy, !busy, !busy & vin};
  endfunction

  function automatic logic [5:0] brev(int c);
    logic [5:0] cc;
    logic [5:0] r;
    cc = c[5:0];
    for (int i = 0; i < 6; i++) r[i] = cc[5-i];
    return r;
  endfunction

  task automatic wait_done1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus1.done_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [5:0] exp_addr [4];
    bit         ok;
    exp_addr = '{6'd0, 6'd32, 6'd16, 6'd48};
    rst = 1'b0;
    bus1.val_i = 1'b1;
    bus0.val_i = 1'b0;
    #22;
    n_chk++;
    if (obs1() !== 21'b0_000_0_0_000_0_0_000000_0_0_1_1)
      $display("FAIL reset_outputs: got %h expected %h", obs1(), 21'b0_000_0_0_000_0_0_000000_0_0_1_1);
    else n_pass++;
    n_chk++;
    if (bus1.wr_addr_o !== 6'd0) $display("FAIL reset_wr_addr: got %0d expected 0", bus1.wr_addr_o);
    else n_pass++;
    n_chk++;
    if (obs0() !== 21'b0_000_0_0_000_0_0_000000_0_0_1_0)
      $display("FAIL reset_outputs_lat0: got %h expected %h", obs0(), 21'b0_000_0_0_000_0_0_000000_0_0_1_0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      #1;
      n_chk++;
      if (bus1.wr_addr_o !== exp_addr[k] || bus1.wr_en_o !== 1'b1)
        $display("FAIL bitrev_sample%0d: got addr %0d en %b expected addr %0d en 1",
                 k, bus1.wr_addr_o, bus1.wr_en_o, exp_addr[k]);
      else n_pass++;
    end
    repeat (61) @(posedge clk);
    @(negedge clk);
    bus1.val_i = 1'b0;
    wait_done1(ok);
    n_chk++;
    if (!ok) $display("FAIL first_frame_done: got no done_o expected done_o within bound");
    else n_pass++;
  endtask

  // Continuous frame with val_i held high through processing.
  task automatic test_frame();
    logic [20:0] e;
    @(negedge clk);
    bus1.val_i = 1'b1;
    repeat (64) @(posedge clk);
    for (int n = 1; n <= 83; n++) begin
      @(negedge clk);
      #1;
      e = exp_vec(n, 1, 1'b1);
      n_chk++;
      if (obs1() !== e) $display("FAIL frame_T+%0d: got %h expected %h", n, obs1(), e);
      else n_pass++;
      if (n == 83) begin
        n_chk++;
        if (bus1.wr_addr_o !== 6'd0) $display("FAIL next_frame_addr: got %0d expected 0", bus1.wr_addr_o);
        else n_pass++;
        bus1.val_i = 1'b0;
      end
    end
  endtask

  task automatic test_gaps();
    int   cnt;
    int   k;
    logic v;
    bit   ok;
    cnt = 0;
    k   = 0;
    while (cnt < 64 && k < 400) begin
      @(negedge clk);
      v = (k % 3 == 0);
      bus1.val_i = v;
      #1;
      n_chk++;
      if ({bus1.rdy_o, bus1.core_val_o, bus1.wr_en_o, bus1.wr_addr_o} !== {1'b1, 1'b0, v, brev(cnt)})
        $display("FAIL gaps_k%0d: got rdy/cv/en/addr %b%b%b/%0d expected 10%b/%0d",
                 k, bus1.rdy_o, bus1.core_val_o, bus1.wr_en_o, bus1.wr_addr_o, v, brev(cnt));
      else n_pass++;
      @(posedge clk);
      if (v) cnt++;
      k++;
    end
    n_chk++;
    if (k !== 190) $display("FAIL gaps_cycles: got %0d expected 190", k);
    else n_pass++;
    @(negedge clk);
    bus1.val_i = 1'b0;
    #1;
    n_chk++;
    if ({bus1.core_val_o, bus1.grp_o, bus1.stg_o, bus1.busy_o} !== {1'b1, 3'd0, 1'b0, 1'b1})
      $display("FAIL gaps_stg0_start: got cv/grp/stg/busy %b/%0d/%b/%b expected 1/0/0/1",
               bus1.core_val_o, bus1.grp_o, bus1.stg_o, bus1.busy_o);
    else n_pass++;
    wait_done1(ok);
    n_chk++;
    if (!ok) $display("FAIL gaps_done: got no done_o expected done_o within bound");
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    int nval;
    int ndone;
    @(negedge clk);
    bus1.val_i = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    bus1.val_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (bus1.core_val_o && bus1.stg_o && bus1.grp_o == 3'd4) ok = 1'b1;
      else @(negedge clk);
    end
    n_chk++;
    if (!ok) $display("FAIL abort_reach_grp4: got no stage-1 group 4 expected it within bound");
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (obs1() !== 21'b0_000_0_0_000_0_0_000000_0_0_1_0)
      $display("FAIL abort_async_clear: got %h expected %h", obs1(), 21'b0_000_0_0_000_0_0_000000_0_0_1_0);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    nval  = 0;
    ndone = 0;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      bus1.val_i = (k < 64);
      #1;
      if (bus1.val_o) nval++;
      if (bus1.done_o) ndone++;
    end
    bus1.val_i = 1'b0;
    n_chk++;
    if (nval !== 64) $display("FAIL abort_val_o_count: got %0d expected 64", nval);
    else n_pass++;
    n_chk++;
    if (ndone !== 1) $display("FAIL abort_done_count: got %0d expected 1", ndone);
    else n_pass++;
  endtask

  task automatic test_lat0();
    logic [20:0] e;
    @(negedge clk);
    bus0.val_i = 1'b1;
    repeat (64) @(posedge clk);
    for (int n = 1; n <= 81; n++) begin
      @(negedge clk);
      if (n == 1) bus0.val_i = 1'b0;
      #1;
      e = exp_vec(n, 0, 1'b0);
      n_chk++;
      if (obs0() !== e) $display("FAIL lat0_T+%0d: got %h expected %h", n, obs0(), e);
      else n_pass++;
    end
  endtask

  initial begin
    bus1.val_i = 1'b0;
    bus0.val_i = 1'b0;
    test_reset();
    test_frame();
    test_gaps();
    test_abort();
    test_lat0();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1);
  end
endmodule
